// File: rtl/sync_fifo_prog_pkg.sv
// sync_fifo_prog_pkg
// Shared definitions for the programmable synchronous FIFO: default
// geometry, the read-mode enumeration and the count-width helper used to
// size occupancy, threshold and high-water-mark fields.
package sync_fifo_prog_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Width needed to hold the values 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_prog_ram.sv
// fifo_ram
// Simple dual-port register array: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
module fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
// Single-clock FIFO with standard or first-word-fall-through read mode,
// runtime-programmable almost-full/almost-empty thresholds, synchronous
// flush, read-valid strobe and a high-water-mark register.
// Ports:
//   clk, rst (async, active high), clr (sync flush)
//   wr_en/data_in        : write side
//   rd_en                : pop request
//   af_thresh/ae_thresh  : almostfull when count >= af, almostempty when count <= ae
//   data_out/rd_valid    : read side
//   wr_ack/overflow/underflow : registered result pulses for the previous cycle
//   full/empty/almostfull/almostempty : flags from the registered count
//   count/hwm            : occupancy and its maximum since reset/clr
module sync_fifo_prog
  import sync_fifo_prog_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int FWFT       = 0,
  parameter int CNT_W      = cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      hwm
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam fifo_mode_e        MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      hwm_q, hwm_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  full_s, empty_s, wr_acc_s, rd_acc_s;
  logic [FIFO_WIDTH-1:0] rdata_s;

  assign full_s  = (count_q == CNT_FULL);
  assign empty_s = (count_q == {CNT_W{1'b0}});

  // A read frees a slot in the same cycle, so a full FIFO still accepts a
  // write alongside an accepted read; an empty FIFO never accepts the read.
  assign rd_acc_s = rd_en && !empty_s && !clr;
  assign wr_acc_s = wr_en && (!full_s || rd_acc_s) && !clr;

  fifo_ram #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_s)
  );

  // Next-state for pointers, occupancy and high-water mark.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hwm_d    = hwm_q;
    if (clr) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
      hwm_d    = {CNT_W{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (count_d > hwm_q) begin
        hwm_d = count_d;
      end else begin
        hwm_d = hwm_q;
      end
    end
  end

  // Pointer, count, hwm and result-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      hwm_q       <= {CNT_W{1'b0}};
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hwm_q       <= hwm_d;
      wr_ack_q    <= wr_acc_s;
      overflow_q  <= wr_en && !wr_acc_s && !clr;
      underflow_q <= rd_en && !rd_acc_s && !clr;
    end
  end

  generate
    if (MODE == FIFO_STD) begin : g_std
      logic [FIFO_WIDTH-1:0] data_out_q;
      logic                  rd_valid_q;

      // Registered read data: captured only on an accepted pop.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_out_q <= {FIFO_WIDTH{1'b0}};
          rd_valid_q <= 1'b0;
        end else if (clr) begin
          data_out_q <= {FIFO_WIDTH{1'b0}};
          rd_valid_q <= 1'b0;
        end else begin
          if (rd_acc_s) begin
            data_out_q <= rdata_s;
          end
          rd_valid_q <= rd_acc_s;
        end
      end

      assign data_out = data_out_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft
      // Head word is presented directly; zero while nothing is stored.
      assign data_out = empty_s ? {FIFO_WIDTH{1'b0}} : rdata_s;
      assign rd_valid = !empty_s;
    end
  endgenerate

  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign full        = full_s;
  assign empty       = empty_s;
  assign almostfull  = (count_q >= af_thresh);
  assign almostempty = (count_q <= ae_thresh);
  assign count       = count_q;
  assign hwm         = hwm_q;

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised successor to the team's synchronous FIFO: single-clock storage with configurable width, depth and read mode (standard or first-word-fall-through).
- Adds runtime-programmable almost-full/almost-empty thresholds, a synchronous flush, a read-valid strobe and a high-water-mark register.
- Sits between producer/consumer blocks on one clock domain; drop-in replacement for the existing FIFO plus new status outputs.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1)
FIFO_DEPTH, 8, number of entries (>=2, need not be a power of 2)
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
CNT_W, $clog2(FIFO_DEPTH+1), derived width of count/threshold/hwm fields

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
clr  in  1  synchronous flush, empties FIFO, clears hwm
wr_en  in  1  write request
data_in  in  FIFO_WIDTH  write data
rd_en  in  1  read/pop request
af_thresh  in  CNT_W  almostfull asserted when count >= af_thresh
ae_thresh  in  CNT_W  almostempty asserted when count <= ae_thresh
data_out  out  FIFO_WIDTH  read data
rd_valid  out  1  data_out holds a freshly popped word (standard mode) / head word valid (FWFT)
wr_ack  out  1  registered pulse: previous-cycle write accepted
overflow  out  1  registered pulse: previous-cycle write rejected (full)
underflow  out  1  registered pulse: previous-cycle read rejected (empty)
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
almostfull  out  1  count >= af_thresh
almostempty  out  1  count <= ae_thresh
count  out  CNT_W  current occupancy
hwm  out  CNT_W  maximum count reached since reset/clr

Behaviour:
- Reset (rst=1, asynchronous): wr_ptr=rd_ptr=0, count=0, hwm=0, data_out=0, rd_valid/wr_ack/overflow/underflow=0. Resulting flags: empty=1, full=0. Storage contents are not reset.
- clr (sync, rst=0): same state as reset on next edge. wr_en/rd_en in the same cycle are ignored, with no ack/overflow/underflow.
- Pointers wrap from FIFO_DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- Write accepted iff wr_en && (!full || read accepted this cycle). Accepted: mem[wr_ptr]<=data_in, wr_ptr++, wr_ack=1 next cycle. Rejected: overflow=1 next cycle.
- Read accepted iff rd_en && !empty. Rejected: underflow=1 next cycle; data_out holds its value.
- Simultaneous accepted read+write: count unchanged.
  - Full + both requested: both occur (pass-through).
  - Empty + both requested: only the write occurs; the read gives underflow.
- count: +1 on write-only, -1 on read-only, else hold. hwm <= max(hwm, next count) each cycle.
- Standard mode (FWFT=0): on accepted read, data_out <= mem[rd_ptr] and rd_valid=1 next cycle (1-cycle latency). Otherwise rd_valid=0 and data_out holds.
- FWFT mode: data_out = mem[rd_ptr] whenever !empty; rd_valid = !empty. A written word appears on data_out the cycle after the write into an empty FIFO. rd_en pops the head, and the next word is visible the following cycle.
- Flags full/empty/almostfull/almostempty are combinational from registered count. Thresholds may change at any time and take effect immediately.
- Threshold edge cases:
  - af_thresh=0: almostfull is always 1.
  - ae_thresh>=FIFO_DEPTH: almostempty is always 1.
  - No error is flagged in either case.

Decomposition:
- Shared_pkg: FIFO_WIDTH and FIFO_DEPTH defaults, localparam CNT_W helper, typedef fifo_mode_e {FIFO_STD, FIFO_FWFT}.
- Sub-module fifo_ram: simple dual-port register array.
  - One write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
- Pointers, count, flags and hwm stay in the top of sync_fifo_prog.

Test Plan:
- Reset mid-traffic: write 3 words, assert rst asynchronously between edges -> count=0, empty=1, wr_ack=0 immediately; hwm=0.
- Fill to full (DEPTH=8, STD): 9 consecutive writes 0x0001..0x0009 -> 8 wr_ack pulses, overflow=1 after the 9th, full=1, count=8, hwm=8. Then read 8 -> data_out 0x0001..0x0008 each 1 cycle after rd_en, with rd_valid=1.
- Simultaneous rd+wr at full: count=8, wr+rd of 0xAAAA -> count stays 8, wr_ack=1, data_out=oldest word. Same at empty -> count=1, underflow=1, wr_ack=1.
- Thresholds: af_thresh=6, ae_thresh=2; write 6 words -> almostfull rises at count=6, almostempty falls at count=3. Change af_thresh to 4 with count=6 -> almostfull stays 1. Change ae_thresh to 7 -> almostempty=1 immediately.
- FWFT=1: write 0x1234 into empty FIFO -> next cycle data_out=0x1234, rd_valid=1 without rd_en. Pop -> empty=1, rd_valid=0. Pointer wrap: 20 interleaved write/read pairs -> data order preserved.
- clr with count=5, hwm=7, wr_en=1 -> next cycle count=0, hwm=0, wr_ack=0, empty=1.
